stage_ex_pipe: RTL and testbench

//  Parametrised, registered MIPS execute stage: operand-B select, ALU, shifter and EX/MEM output register.

---
 rtl/stage_ex_pipe.sv | 247 ++++++++++++++++++++++++
 tb/tb_stage_ex_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_ex_pipe.sv
// stage_ex_pipe -- registered MIPS execute stage.
//
// Selects operand B (readRt or signExt), evaluates the ALU/shifter operation
// named by instReg and captures the result in a single-entry EX/MEM register.
// Overflow is flagged for ADD/SUB. Unsupported funct codes are flagged through
// illegalOp.
//
// Optional feature: define STAGE_EX_MULDIV_EN to build the iterative MULTU unit
// (IDLE/MUL/DONE FSM, shift-add datapath, HI/LO registers). When it is undefined,
// MULTU is an illegal op, HI/LO read as 0 and the stage never stalls internally.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both 1.
// The producer holds valid and its payload stable until that edge. The output
// register holds outAlu/zeroAlu/ovfAlu/illegalOp stable while outValid=1 and
// outReady=0. A drain and an accept can happen on the same edge.
//
// Ports:
//   clk, rstN            clock, asynchronous active-low reset
//   inValid / inReady    ID/EX -> EX handshake
//   readRs, readRt       operand A, operand B candidate 0
//   signExt              operand B candidate 1 (immediate)
//   sa                   constant shift amount
//   instReg              funct code
//   btnMuxEx             0: B = readRt, 1: B = signExt
//   outValid / outReady  EX -> MEM handshake
//   outAlu, zeroAlu      registered result and its zero flag
//   ovfAlu, illegalOp    registered signed-overflow and illegal-op flags
//   dbgState             current multiplier FSM state (always IDLE without the unit)
module stage_ex_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               inValid,
    output logic               inReady,
    input  logic [WIDTH-1:0]   readRs,
    input  logic [WIDTH-1:0]   readRt,
    input  logic [WIDTH-1:0]   signExt,
    input  logic [SHAMT_W-1:0] sa,
    input  logic [FUNCT_W-1:0] instReg,
    input  logic               btnMuxEx,
    output logic               outValid,
    input  logic               outReady,
    output logic [WIDTH-1:0]   outAlu,
    output logic               zeroAlu,
    output logic               ovfAlu,
    output logic               illegalOp,
    output logic [1:0]         dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } exState_t;

    localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'('h00);
    localparam logic [FUNCT_W-1:0] F_SRL   = FUNCT_W'('h02);
    localparam logic [FUNCT_W-1:0] F_SRA   = FUNCT_W'('h03);
    localparam logic [FUNCT_W-1:0] F_SLLV  = FUNCT_W'('h04);
    localparam logic [FUNCT_W-1:0] F_SRLV  = FUNCT_W'('h06);
    localparam logic [FUNCT_W-1:0] F_SRAV  = FUNCT_W'('h07);
    localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'('h10);
    localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'('h12);
    localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'('h20);
    localparam logic [FUNCT_W-1:0] F_ADDU  = FUNCT_W'('h21);
    localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'('h22);
    localparam logic [FUNCT_W-1:0] F_SUBU  = FUNCT_W'('h23);
    localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'('h24);
    localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'('h25);
    localparam logic [FUNCT_W-1:0] F_XOR   = FUNCT_W'('h26);
    localparam logic [FUNCT_W-1:0] F_NOR   = FUNCT_W'('h27);
    localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'('h2A);
    localparam logic [FUNCT_W-1:0] F_SLTU  = FUNCT_W'('h2B);
`ifdef STAGE_EX_MULDIV_EN
    localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'('h19);
`endif

    exState_t         state;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             isMulOp;
    logic             mulDone;
    logic [WIDTH-1:0] mulLow;

    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] sumAB;
    logic [WIDTH-1:0] diffAB;
    logic [WIDTH-1:0] aluRes;
    logic             aluOvf;
    logic             aluIll;
    logic             accept;

    assign opB    = btnMuxEx ? signExt : readRt;
    assign sumAB  = readRs + opB;
    assign diffAB = readRs - opB;

    assign inReady  = (state == IDLE) && (!outValid || outReady);
    assign accept   = inValid && inReady;
    assign dbgState = state;

    // ------------------------------------------------------------------
    // Combinational ALU / shifter
    // ------------------------------------------------------------------
    always_comb begin
        aluRes = '0;
        aluOvf = 1'b0;
        aluIll = 1'b0;
        case (instReg)
            // Signed overflow: operands of equal sign produce a result of the other sign.
            F_ADD: begin
                aluRes = sumAB;
                aluOvf = (readRs[WIDTH-1] == opB[WIDTH-1]) && (sumAB[WIDTH-1] != readRs[WIDTH-1]);
            end
            F_ADDU: aluRes = sumAB;
            // Subtraction overflows only when the operand signs differ.
            F_SUB: begin
                aluRes = diffAB;
                aluOvf = (readRs[WIDTH-1] != opB[WIDTH-1]) && (diffAB[WIDTH-1] != readRs[WIDTH-1]);
            end
            F_SUBU: aluRes = diffAB;
            F_AND:  aluRes = readRs & opB;
            F_OR:   aluRes = readRs | opB;
            F_XOR:  aluRes = readRs ^ opB;
            F_NOR:  aluRes = ~(readRs | opB);
            F_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(readRs) < $signed(opB))};
            F_SLTU: aluRes = {{(WIDTH-1){1'b0}}, (readRs < opB)};
            F_SLL:  aluRes = opB << sa;
            F_SRL:  aluRes = opB >> sa;
            F_SRA:  aluRes = $signed(opB) >>> sa;
            F_SLLV: aluRes = opB << readRs[SHAMT_W-1:0];
            F_SRLV: aluRes = opB >> readRs[SHAMT_W-1:0];
            F_SRAV: aluRes = $signed(opB) >>> readRs[SHAMT_W-1:0];
            F_MFHI: aluRes = hiReg;
            F_MFLO: aluRes = loReg;
`ifdef STAGE_EX_MULDIV_EN
            // The result of the multiply comes later from the FSM.
            F_MULTU: aluRes = '0;
`endif
            default: begin
                aluRes = '0;
                aluIll = 1'b1;
            end
        endcase
    end

`ifdef STAGE_EX_MULDIV_EN
    // ------------------------------------------------------------------
    // Iterative shift-add multiplier: one partial product per cycle
    // ------------------------------------------------------------------
    exState_t           nextState;
    logic [SHAMT_W-1:0] mulCnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;

    assign isMulOp = (instReg == F_MULTU);
    assign mulDone = (state == DONE);
    assign mulLow  = prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept && isMulOp) nextState = MUL;
            MUL:     if (mulCnt == SHAMT_W'(WIDTH-1)) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mulCnt <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            hiReg  <= '0;
            loReg  <= '0;
        end else begin
            case (state)
                IDLE: if (accept && isMulOp) begin
                    // The operands are latched here, so later changes on the inputs are ignored.
                    mcand  <= {{WIDTH{1'b0}}, readRs};
                    mplier <= opB;
                    prod   <= '0;
                    mulCnt <= '0;
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    mulCnt <= mulCnt + 1'b1;
                end
                DONE: begin
                    hiReg <= prod[2*WIDTH-1:WIDTH];
                    loReg <= prod[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end
`else
    assign state   = IDLE;
    assign isMulOp = 1'b0;
    assign mulDone = 1'b0;
    assign mulLow  = '0;
    assign hiReg   = '0;
    assign loReg   = '0;
`endif

    // ------------------------------------------------------------------
    // EX/MEM output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            outValid  <= 1'b0;
            outAlu    <= '0;
            zeroAlu   <= 1'b0;
            ovfAlu    <= 1'b0;
            illegalOp <= 1'b0;
        end else begin
            if (outValid && outReady) outValid <= 1'b0;
            if (accept && !isMulOp) begin
                outValid  <= 1'b1;
                outAlu    <= aluRes;
                zeroAlu   <= (aluRes == '0);
                ovfAlu    <= aluOvf;
                illegalOp <= aluIll;
            end else if (mulDone) begin
                // The output register is always empty here: nothing else loads it during MUL.
                outValid  <= 1'b1;
                outAlu    <= mulLow;
                zeroAlu   <= (mulLow == '0);
                ovfAlu    <= 1'b0;
                illegalOp <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stage_ex_pipe.sv
module tb_stage_ex_pipe;
  localparam int W = 32;
  localparam int EW = W + 3;

  logic         clk;
  logic         rstN;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] readRs;
  logic [W-1:0] readRt;
  logic [W-1:0] signExt;
  logic [4:0]   sa;
  logic [5:0]   instReg;
  logic         btnMuxEx;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] outAlu;
  logic         zeroAlu;
  logic         ovfAlu;
  logic         illegalOp;
  logic [1:0]   dbgState;

  int checks = 0;
  int errors = 0;

  // expected token: {illegalOp, ovfAlu, zeroAlu, outAlu}
  logic [EW-1:0] exp_q[$];

  stage_ex_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .readRs(readRs), .readRt(readRt), .signExt(signExt), .sa(sa),
    .instReg(instReg), .btnMuxEx(btnMuxEx), .outValid(outValid),
    .outReady(outReady), .outAlu(outAlu), .zeroAlu(zeroAlu),
    .ovfAlu(ovfAlu), .illegalOp(illegalOp), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [EW-1:0] tok(input logic [W-1:0] alu, input logic ovf, input logic ill);
    return {ill, ovf, (alu == '0), alu};
  endfunction

  // driver: present one op, wait (bounded) for acceptance, push its expected token
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] rt, input logic [W-1:0] se,
                       input logic [4:0] s, input logic [5:0] f, input logic mux,
                       input logic [EW-1:0] e);
    int n;
    readRs = a; readRt = rt; signExt = se; sa = s; instReg = f; btnMuxEx = mux;
    inValid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!inReady && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!inReady) begin
      chk("accept_timeout", 1, 0);
      inValid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1 inValid = 1'b0;
  endtask

  // monitor / scoreboard: compare every token MEM consumes
  always @(negedge clk) begin
    if (rstN && outValid && outReady) begin
      if (exp_q.size() == 0) chk("unexpected_token", 1, 0);
      else chk("token", {29'd0, illegalOp, ovfAlu, zeroAlu, outAlu}, {29'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstN = 1'b0; inValid = 1'b0; outReady = 1'b1;
    readRs = '0; readRt = '0; signExt = '0; sa = '0; instReg = '0; btnMuxEx = 1'b0;
    #12;
    chk("rst_outValid", outValid, 0);
    chk("rst_outs", {illegalOp, ovfAlu, zeroAlu, outAlu}, 0);
    @(negedge clk) rstN = 1'b1;
    @(negedge clk);
    chk("rst_inReady", inReady, 1);
    @(posedge clk); #1;

    // 1: basic ADD with one-cycle latency
    issue(32'd5, 32'd7, 32'd0, 5'd0, 6'h20, 1'b0, tok(32'd12, 0, 0));
    chk("latency_outValid", outValid, 1);

    // 2: overflow and zero
    issue(32'h7FFFFFFF, 32'd9, 32'd1, 5'd0, 6'h20, 1'b1, tok(32'h80000000, 1, 0));
    issue(32'd3, 32'd3, 32'd0, 5'd0, 6'h22, 1'b0, tok(32'd0, 0, 0));
    issue(32'h7FFFFFFF, 32'd1, 32'd0, 5'd0, 6'h21, 1'b0, tok(32'h80000000, 0, 0));
    issue(32'h80000000, 32'd1, 32'd0, 5'd0, 6'h22, 1'b0, tok(32'h7FFFFFFF, 1, 0));
    issue(32'd0, 32'd1, 32'd0, 5'd0, 6'h23, 1'b0, tok(32'hFFFFFFFF, 0, 0));

    // 3: shifts, compares, logic, illegal
    issue(32'd0, 32'h80000000, 32'd0, 5'd4, 6'h03, 1'b0, tok(32'hF8000000, 0, 0));
    issue(32'd0, 32'd1, 32'd0, 5'd31, 6'h00, 1'b0, tok(32'h80000000, 0, 0));
    issue(32'd0, 32'h80000000, 32'd0, 5'd4, 6'h02, 1'b0, tok(32'h08000000, 0, 0));
    issue(32'd4, 32'hF0, 32'd0, 5'd0, 6'h06, 1'b0, tok(32'h0000000F, 0, 0));
    issue(32'h24, 32'h80000000, 32'd0, 5'd0, 6'h07, 1'b0, tok(32'hF8000000, 0, 0));
    issue(32'd8, 32'h3, 32'd0, 5'd0, 6'h04, 1'b0, tok(32'h00000300, 0, 0));
    issue(32'hFFFFFFFF, 32'd1, 32'd0, 5'd0, 6'h2A, 1'b0, tok(32'd1, 0, 0));
    issue(32'hFFFFFFFF, 32'd1, 32'd0, 5'd0, 6'h2B, 1'b0, tok(32'd0, 0, 0));
    issue(32'hF0F0, 32'h0, 32'hFF00, 5'd0, 6'h24, 1'b1, tok(32'h0000F000, 0, 0));
    issue(32'hF0F0, 32'hFF00, 32'd0, 5'd0, 6'h25, 1'b0, tok(32'h0000FFF0, 0, 0));
    issue(32'hF0F0, 32'hFF00, 32'd0, 5'd0, 6'h26, 1'b0, tok(32'h00000FF0, 0, 0));
    issue(32'hF0F0, 32'hFF00, 32'd0, 5'd0, 6'h27, 1'b0, tok(32'hFFFF000F, 0, 0));
    issue(32'd1, 32'd2, 32'd0, 5'd0, 6'h3F, 1'b0, tok(32'd0, 0, 1));
    issue(32'd0, 32'd0, 32'd0, 5'd0, 6'h10, 1'b0, tok(32'd0, 0, 0));

    // 4: back-to-back ADDs with MEM stalled for 3 cycles
    @(posedge clk); #1 outReady = 1'b0;
    issue(32'd1, 32'd1, 32'd0, 5'd0, 6'h20, 1'b0, tok(32'd2, 0, 0));
    fork
      issue(32'd2, 32'd2, 32'd0, 5'd0, 6'h20, 1'b0, tok(32'd4, 0, 0));
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_outValid", outValid, 1);
          chk("stall_outAlu", outAlu, 32'd2);
          chk("stall_inReady", inReady, 0);
        end
        @(posedge clk); #1 outReady = 1'b1;
      end
    join
    issue(32'd10, 32'd0, 32'd0, 5'd0, 6'h21, 1'b0, tok(32'd10, 0, 0));

    // 5: MULTU
`ifdef STAGE_EX_MULDIV_EN
    issue(32'hFFFFFFFF, 32'd2, 32'd0, 5'd0, 6'h19, 1'b0, tok(32'hFFFFFFFE, 0, 0));
    n = 0;
    @(negedge clk);
    while (!inReady && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mul_stall_cycles", n, W + 1);
    @(posedge clk); #1;
    issue(32'd0, 32'd0, 32'd0, 5'd0, 6'h10, 1'b0, tok(32'd1, 0, 0));
    issue(32'd0, 32'd0, 32'd0, 5'd0, 6'h12, 1'b0, tok(32'hFFFFFFFE, 0, 0));
`else
    issue(32'hFFFFFFFF, 32'd2, 32'd0, 5'd0, 6'h19, 1'b0, tok(32'd0, 0, 1));
    @(negedge clk);
    chk("multu_no_stall", inReady, 1);
    @(posedge clk); #1;
    issue(32'd0, 32'd0, 32'd0, 5'd0, 6'h10, 1'b0, tok(32'd0, 0, 0));
    issue(32'd0, 32'd0, 32'd0, 5'd0, 6'h12, 1'b0, tok(32'd0, 0, 0));
`endif

    // 6: reset in the middle of work
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    #1;
`ifdef STAGE_EX_MULDIV_EN
    issue(32'd7, 32'd9, 32'd0, 5'd0, 6'h19, 1'b0, tok(32'd63, 0, 0));
    repeat (10) @(posedge clk);
    #1 rstN = 1'b0;
`else
    outReady = 1'b0;
    issue(32'd7, 32'd9, 32'd0, 5'd0, 6'h20, 1'b0, tok(32'd16, 0, 0));
    #1 rstN = 1'b0;
`endif
    exp_q.delete();
    #1;
    chk("midrst_outValid", outValid, 0);
    chk("midrst_outAlu", outAlu, 0);
    outReady = 1'b1;
    @(negedge clk) rstN = 1'b1;
    @(negedge clk);
    chk("midrst_inReady", inReady, 1);
    @(posedge clk); #1;
    issue(32'd0, 32'd0, 32'd0, 5'd0, 6'h10, 1'b0, tok(32'd0, 0, 0));
    issue(32'd0, 32'd0, 32'd0, 5'd0, 6'h12, 1'b0, tok(32'd0, 0, 0));
    issue(32'd2, 32'd3, 32'd0, 5'd0, 6'h20, 1'b0, tok(32'd5, 0, 0));

    // drain and report
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
